mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte-serial little-endian loads/stores over an
// 8-bit RAM port, upstream stall, and a registered write-back tuple.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  e_i,
  input  logic [31:0] res_i,
  input  logic [31:0] n_i,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wa_o,
  output logic        we_o,
  output logic [31:0] wn_o,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic [7:0]  mem_din
);

  typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_t;

  state_t      state;
  logic [1:0]  k;
  logic [1:0]  last_k;
  logic [1:0]  len_q;
  logic        uns_q;
  logic [4:0]  wa_q;
  logic        we_q;
  logic [31:0] store_q;
  logic [31:0] asm_q;

  function automatic logic [31:0] place(input logic [31:0] word, input logic [1:0] lane,
                                        input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] len,
                                         input logic uns);
    case (len)
      2'd0:    return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Accept-cycle stall must be seen by EX before the edge, so it cannot be registered.
  assign stall_o = !rst && ((state != IDLE) || (valid_i && e_i[4]));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      last_k     <= 2'd0;
      len_q      <= 2'd0;
      uns_q      <= 1'b0;
      wa_q       <= 5'd0;
      we_q       <= 1'b0;
      store_q    <= 32'd0;
      asm_q      <= 32'd0;
      wb_valid_o <= 1'b0;
      wa_o       <= 5'd0;
      we_o       <= 1'b0;
      wn_o       <= 32'd0;
      mem_a      <= 32'd0;
      mem_dout   <= 8'd0;
      mem_wr     <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            wa_q   <= wa_i;
            we_q   <= we_i;
            len_q  <= e_i[3:2];
            uns_q  <= e_i[0];
            k      <= 2'd0;
            last_k <= (e_i[3:2] == 2'd0) ? 2'd0 : (e_i[3:2] == 2'd1) ? 2'd1 : 2'd3;
            if (!e_i[4]) begin
              wb_valid_o <= 1'b1;
              wa_o       <= wa_i;
              we_o       <= we_i;
              wn_o       <= res_i;
            end else if (!e_i[1]) begin
              state <= RD;
              mem_a <= res_i;
              asm_q <= 32'd0;
            end else begin
              state    <= WR;
              mem_a    <= res_i;
              mem_dout <= n_i[7:0];
              mem_wr   <= 1'b1;
              store_q  <= {8'd0, n_i[31:8]};
            end
          end
        end
        RD: begin
          // mem_din carries the byte addressed in the previous cycle (lane k-1).
          if (k != 2'd0) asm_q <= place(asm_q, k - 2'd1, mem_din);
          if (k == last_k) begin
            state <= RDW;
            mem_a <= 32'd0;
          end else begin
            k     <= k + 2'd1;
            mem_a <= mem_a + 32'd1;
          end
        end
        RDW: begin
          state      <= IDLE;
          wb_valid_o <= 1'b1;
          wa_o       <= wa_q;
          we_o       <= we_q;
          wn_o       <= extend(place(asm_q, k, mem_din), len_q, uns_q);
        end
        WR: begin
          if (k == last_k) begin
            state      <= IDLE;
            mem_a      <= 32'd0;
            mem_dout   <= 8'd0;
            mem_wr     <= 1'b0;
            wb_valid_o <= 1'b1;
            wa_o       <= wa_q;
            we_o       <= 1'b0;
          end else begin
            k        <= k + 2'd1;
            mem_a    <= mem_a + 32'd1;
            mem_dout <= store_q[7:0];
            store_q  <= {8'd0, store_q[31:8]};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte RAM environment, directed and random loads/stores
// checked against a sparse-memory reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [4:0]  e_i = 5'd0;
  logic [31:0] res_i = 32'd0;
  logic [31:0] n_i = 32'd0;
  logic [4:0]  wa_i = 5'd0;
  logic        we_i = 1'b0;
  logic        stall_o, wb_valid_o, we_o, mem_wr;
  logic [4:0]  wa_o;
  logic [31:0] wn_o, mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'd0;

  int total = 0;
  int bad = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_ram [logic [31:0]];

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .e_i(e_i), .res_i(res_i), .n_i(n_i),
    .wa_i(wa_i), .we_i(we_i), .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wa_o(wa_o),
    .we_o(we_o), .wn_o(wn_o), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
  endfunction

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_ram[a] = b;
  endtask

  // Issues one instruction at the current negedge and checks every cycle up to
  // and including its write-back cycle; returns at that cycle's negedge.
  task automatic run_op(input logic en, input logic [1:0] len, input logic wr, input logic uns,
                        input logic [31:0] res, input logic [31:0] n, input logic [4:0] wa,
                        input logic we);
    int nb, lat;
    logic [31:0] v, a;
    logic [7:0] b;
    logic phase;
    nb  = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    lat = !en ? 1 : (wr ? nb + 1 : nb + 2);
    v = 32'd0;
    for (int i = 0; i < nb; i++) v = v + (32'(ref_rd(res + 32'(i))) << (8 * i));
    if (!uns && nb == 1 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    if (!uns && nb == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;

    valid_i = 1'b1; e_i = {en, len, wr, uns}; res_i = res; n_i = n; wa_i = wa; we_i = we;
    #1 chk("stall_accept", 32'(stall_o), 32'(en));
    @(posedge clk);
    #1 valid_i = 1'b0; e_i = 5'd0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      phase = en && (c <= nb);
      a     = res + 32'(c - 1);
      b     = 8'(n >> (8 * (c - 1)));
      chk("stall", 32'(stall_o), 32'(en && (c < lat)));
      chk("wb_valid", 32'(wb_valid_o), 32'(c == lat));
      chk("mem_a", mem_a, phase ? a : 32'd0);
      chk("mem_wr", 32'(mem_wr), 32'(phase && wr));
      if (wr || !phase) chk("mem_dout", 32'(mem_dout), (phase && wr) ? 32'(b) : 32'd0);
      if (phase && wr) ref_ram[a] = b;
      if (c == lat) begin
        if (!en) begin
          chk("wn_pass", wn_o, res);
          chk("wa_pass", 32'(wa_o), 32'(wa));
          chk("we_pass", 32'(we_o), 32'(we));
        end else if (!wr) begin
          chk("wn_load", wn_o, v);
          chk("wa_load", 32'(wa_o), 32'(wa));
          chk("we_load", 32'(we_o), 32'(we));
        end else begin
          chk("we_store", 32'(we_o), 32'd0);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] addr;

    // Reset state
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_wb", 32'(wb_valid_o), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_wn", wn_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Non-memory pass-through
    run_op(1'b0, 2'd0, 1'b0, 1'b0, 32'h1234_5678, 32'd0, 5'd5, 1'b1);
    chk("pass_value", wn_o, 32'h1234_5678);

    // lw, lb/lbu, lh/lhu
    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    run_op(1'b1, 2'd3, 1'b0, 1'b0, 32'h100, 32'd0, 5'd7, 1'b1);
    chk("lw_value", wn_o, 32'h1234_5678);
    preload(32'h20, 8'h80);
    run_op(1'b1, 2'd0, 1'b0, 1'b0, 32'h20, 32'd0, 5'd8, 1'b1);
    chk("lb_value", wn_o, 32'hFFFF_FF80);
    run_op(1'b1, 2'd0, 1'b0, 1'b1, 32'h20, 32'd0, 5'd9, 1'b1);
    chk("lbu_value", wn_o, 32'h0000_0080);
    preload(32'h40, 8'h00); preload(32'h41, 8'h80);
    run_op(1'b1, 2'd1, 1'b0, 1'b0, 32'h40, 32'd0, 5'd10, 1'b1);
    chk("lh_value", wn_o, 32'hFFFF_8000);
    run_op(1'b1, 2'd1, 1'b0, 1'b1, 32'h40, 32'd0, 5'd11, 1'b1);
    chk("lhu_value", wn_o, 32'h0000_8000);

    // sw, sh, len=2 treated as word
    run_op(1'b1, 2'd3, 1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, 5'd1, 1'b1);
    chk("sw_ram0", 32'(ram_rd(32'h200)), 32'hEF);
    chk("sw_ram3", 32'(ram_rd(32'h203)), 32'hDE);
    preload(32'h212, 8'hAA);
    run_op(1'b1, 2'd1, 1'b1, 1'b0, 32'h210, 32'h1122_3344, 5'd2, 1'b1);
    chk("sh_untouched", 32'(ram_rd(32'h212)), 32'hAA);
    run_op(1'b1, 2'd2, 1'b0, 1'b0, 32'h200, 32'd0, 5'd3, 1'b1);
    chk("len2_value", wn_o, 32'hDEAD_BEEF);

    // Address wrap-around
    preload(32'hFFFF_FFFE, 8'h01); preload(32'hFFFF_FFFF, 8'h02);
    preload(32'h0000_0000, 8'h03); preload(32'h0000_0001, 8'h04);
    run_op(1'b1, 2'd3, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd0, 5'd12, 1'b1);
    chk("wrap_value", wn_o, 32'h0403_0201);

    // Reset in the middle of a word store, after two bytes
    preload(32'h502, 8'h55); preload(32'h503, 8'h55);
    valid_i = 1'b1; e_i = {1'b1, 2'd3, 1'b1, 1'b0}; res_i = 32'h500; n_i = 32'hA1B2_C3D4;
    @(posedge clk);
    #1 valid_i = 1'b0; e_i = 5'd0;
    @(negedge clk);
    chk("abort_b0", mem_a, 32'h500);
    ref_ram[32'h500] = 8'hD4;
    @(negedge clk);
    chk("abort_b1", mem_a, 32'h501);
    ref_ram[32'h501] = 8'hC3;
    @(negedge clk);
    chk("abort_pre_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_wr", 32'(mem_wr), 32'd0);
    chk("abort_stall", 32'(stall_o), 32'd0);
    chk("abort_mem_a", mem_a, 32'd0);
    valid_i = 1'b1; e_i = {1'b1, 2'd0, 1'b0, 1'b0};
    #1 chk("rst_stall_gated", 32'(stall_o), 32'd0);
    valid_i = 1'b0; e_i = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_wb", 32'(wb_valid_o), 32'd0);
      chk("abort_idle", 32'(stall_o), 32'd0);
    end
    preload(32'h10, 8'h9C);
    run_op(1'b1, 2'd0, 1'b0, 1'b0, 32'h10, 32'd0, 5'd13, 1'b1);
    chk("post_abort_lb", wn_o, 32'hFFFF_FF9C);
    run_op(1'b1, 2'd3, 1'b0, 1'b0, 32'h500, 32'd0, 5'd14, 1'b1);
    chk("abort_partial", wn_o, 32'h5555_C3D4);

    // Randomized mix, mostly back-to-back
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       addr = 32'h300 + 32'($urandom_range(0, 31));
        1:       addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: addr = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0)
        run_op(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, $urandom,
               $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else
        run_op(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), (addr[31:8] == 24'hFFFFFF || addr[31:8] == 24'h3)
               ? addr : 32'h300 + 32'($urandom_range(0, 31)),
               $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        chk("gap_wb", 32'(wb_valid_o), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
